// File: rtl/rocc_cmd_pkg.sv
// rocc_cmd_pkg: shared types and constants for the RoCC command dispatch slice.
//   cmd_t                 : one buffered compute command {funct, rd, rs1, rs2}, 140 bits
//   FUNCT_CFG_WR_DEFAULT  : default funct code that selects a config-register write
//   CMD_COUNT_W           : width of the forwarded-command counter
package rocc_cmd_pkg;

  typedef struct packed {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } cmd_t;

  localparam logic [6:0]  FUNCT_CFG_WR_DEFAULT = 7'h00;
  localparam int unsigned CMD_COUNT_W          = 32;

endpackage

// File: rtl/rocc_cmd_fifo.sv
// rocc_cmd_fifo: synchronous FIFO holding elements of type T.
//   clock, reset : clock and asynchronous active-low reset
//   push         : enqueue push_data (ignored while full)
//   full         : no space left
//   pop          : dequeue the head entry (ignored while empty)
//   empty        : no entries held
//   head         : oldest entry, all-zero while empty
//   occupancy    : number of entries held
module rocc_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  T                        push_data,
  output logic                    full,
  input  logic                    pop,
  output logic                    empty,
  output T                        head,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic           do_push;
  logic           do_pop;

  assign full      = (occ == (AW+1)'(DEPTH));
  assign empty     = (occ == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign occupancy = occ;
  // Storage is not reset; gating keeps the visible head at zero while empty.
  assign head      = empty ? T'('0) : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/rocc_cmd_dispatch.sv
// rocc_cmd_dispatch: front end between the RoCC command port and the accelerator core.
// Config writes are applied locally once all compute work has drained; compute commands
// are buffered in a FIFO and forwarded over a valid/ready handshake.
//   clock, reset        : clock and asynchronous active-low reset
//   io_cmd_*            : CPU command port (valid/ready, funct, rd, rs1, rs2)
//   acc_cmd_*           : command stream to the core (valid/ready, head entry fields)
//   acc_idle            : core has no command in progress
//   cfg_regs            : flattened config registers, reg i at [i*W +: W]
//   busy                : FIFO non-empty or core not idle
//   cfg_err             : sticky flag for an out-of-range config index
//   cmd_count           : compute commands handed to the core (wraps)
module rocc_cmd_dispatch
  import rocc_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned NUM_OF_CFG_REGS = 3,
  parameter int unsigned CFG_REG_WIDTH   = 32,
  parameter logic [6:0]  FUNCT_CFG_WR    = FUNCT_CFG_WR_DEFAULT
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    io_cmd_valid,
  output logic                                    io_cmd_ready,
  input  logic [6:0]                              io_cmd_bits_inst_funct,
  input  logic [4:0]                              io_cmd_bits_inst_rd,
  input  logic [63:0]                             io_cmd_bits_rs1,
  input  logic [63:0]                             io_cmd_bits_rs2,
  output logic                                    acc_cmd_valid,
  input  logic                                    acc_cmd_ready,
  output logic [6:0]                              acc_cmd_funct,
  output logic [4:0]                              acc_cmd_rd,
  output logic [63:0]                             acc_cmd_rs1,
  output logic [63:0]                             acc_cmd_rs2,
  input  logic                                    acc_idle,
  output logic [NUM_OF_CFG_REGS*CFG_REG_WIDTH-1:0] cfg_regs,
  output logic                                    busy,
  output logic                                    cfg_err,
  output logic [CMD_COUNT_W-1:0]                  cmd_count
);

  cmd_t                         in_cmd;
  cmd_t                         head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  occupancy;
  logic                         is_cfg;
  logic                         cfg_fire;
  logic                         cmp_fire;
  logic                         acc_fire;
  logic [31:0]                  cfg_idx;
  logic [CFG_REG_WIDTH-1:0]     regs [NUM_OF_CFG_REGS];

  assign is_cfg  = (io_cmd_bits_inst_funct == FUNCT_CFG_WR);
  assign cfg_idx = io_cmd_bits_rs1[31:0];

  // Config writes wait for an empty queue and an idle core so they never overtake compute work.
  assign io_cmd_ready = is_cfg ? (fifo_empty & acc_idle) : ~fifo_full;
  assign cfg_fire     = io_cmd_valid & io_cmd_ready & is_cfg;
  assign cmp_fire     = io_cmd_valid & io_cmd_ready & ~is_cfg;
  assign acc_fire     = acc_cmd_valid & acc_cmd_ready;

  assign in_cmd = '{funct: io_cmd_bits_inst_funct, rd: io_cmd_bits_inst_rd,
                    rs1: io_cmd_bits_rs1, rs2: io_cmd_bits_rs2};

  rocc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cmp_fire),
    .push_data (in_cmd),
    .full      (fifo_full),
    .pop       (acc_fire),
    .empty     (fifo_empty),
    .head      (head),
    .occupancy (occupancy)
  );

  assign acc_cmd_valid = ~fifo_empty;
  assign acc_cmd_funct = head.funct;
  assign acc_cmd_rd    = head.rd;
  assign acc_cmd_rs1   = head.rs1;
  assign acc_cmd_rs2   = head.rs2;

  assign busy = (occupancy != '0) | ~acc_idle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_OF_CFG_REGS; i++) regs[i] <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_fire) begin
      if (cfg_idx < NUM_OF_CFG_REGS) begin
        for (int unsigned i = 0; i < NUM_OF_CFG_REGS; i++) begin
          if (cfg_idx == i) regs[i] <= io_cmd_bits_rs2[CFG_REG_WIDTH-1:0];
        end
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_count <= '0;
    end else if (acc_fire) begin
      cmd_count <= cmd_count + CMD_COUNT_W'(1);
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NUM_OF_CFG_REGS; i++) begin
      cfg_regs[i*CFG_REG_WIDTH +: CFG_REG_WIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_rocc_cmd_dispatch.sv
// tb_rocc_cmd_dispatch: directed and randomized stimulus with a queue-based reference model.
// The driver pushes accepted compute commands into exp_q; a negedge monitor compares the
// presented head, counters and config state and pops on each output handshake.
module tb_rocc_cmd_dispatch;
  import rocc_cmd_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 3;
  localparam int unsigned W     = 32;

  logic                 clock;
  logic                 reset;
  logic                 io_cmd_valid;
  logic                 io_cmd_ready;
  logic [6:0]           io_cmd_bits_inst_funct;
  logic [4:0]           io_cmd_bits_inst_rd;
  logic [63:0]          io_cmd_bits_rs1;
  logic [63:0]          io_cmd_bits_rs2;
  logic                 acc_cmd_valid;
  logic                 acc_cmd_ready;
  logic [6:0]           acc_cmd_funct;
  logic [4:0]           acc_cmd_rd;
  logic [63:0]          acc_cmd_rs1;
  logic [63:0]          acc_cmd_rs2;
  logic                 acc_idle;
  logic [NREG*W-1:0]    cfg_regs;
  logic                 busy;
  logic                 cfg_err;
  logic [31:0]          cmd_count;

  rocc_cmd_dispatch #(
    .FIFO_DEPTH      (DEPTH),
    .NUM_OF_CFG_REGS (NREG),
    .CFG_REG_WIDTH   (W),
    .FUNCT_CFG_WR    (7'h00)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_cmd_valid           (io_cmd_valid),
    .io_cmd_ready           (io_cmd_ready),
    .io_cmd_bits_inst_funct (io_cmd_bits_inst_funct),
    .io_cmd_bits_inst_rd    (io_cmd_bits_inst_rd),
    .io_cmd_bits_rs1        (io_cmd_bits_rs1),
    .io_cmd_bits_rs2        (io_cmd_bits_rs2),
    .acc_cmd_valid          (acc_cmd_valid),
    .acc_cmd_ready          (acc_cmd_ready),
    .acc_cmd_funct          (acc_cmd_funct),
    .acc_cmd_rd             (acc_cmd_rd),
    .acc_cmd_rs1            (acc_cmd_rs1),
    .acc_cmd_rs2            (acc_cmd_rs2),
    .acc_idle               (acc_idle),
    .cfg_regs               (cfg_regs),
    .busy                   (busy),
    .cfg_err                (cfg_err),
    .cmd_count              (cmd_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;

  // Reference model
  cmd_t        exp_q[$];
  logic [W-1:0] m_cfg [NREG];
  logic        m_err;
  logic [31:0] m_count;
  logic        pend_push;
  cmd_t        pend_cmd;
  logic        pend_cfg;
  logic [31:0] pend_idx;
  logic [W-1:0] pend_data;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREG*W-1:0] model_flat();
    logic [NREG*W-1:0] f;
    f = '0;
    for (int i = 0; i < int'(NREG); i++) f[i*W +: W] = m_cfg[i];
    return f;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < int'(NREG); i++) m_cfg[i] = '0;
    m_err     = 1'b0;
    m_count   = '0;
    pend_push = 1'b0;
    pend_cfg  = 1'b0;
  endtask

  // Apply the effect of the transaction accepted at the edge just passed.
  task automatic commit();
    if (pend_push) exp_q.push_back(pend_cmd);
    if (pend_cfg) begin
      if (pend_idx < NREG) begin
        for (int i = 0; i < int'(NREG); i++) if (pend_idx == 32'(i)) m_cfg[i] = pend_data;
      end else begin
        m_err = 1'b1;
      end
    end
    pend_push = 1'b0;
    pend_cfg  = 1'b0;
  endtask

  task automatic step(input logic v, input logic [6:0] f, input logic [4:0] rd,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic ardy, input logic idle);
    logic is_cfg;
    logic er;
    @(posedge clock);
    #1;
    commit();
    io_cmd_valid           = v;
    io_cmd_bits_inst_funct = f;
    io_cmd_bits_inst_rd    = rd;
    io_cmd_bits_rs1        = a;
    io_cmd_bits_rs2        = b;
    acc_cmd_ready          = ardy;
    acc_idle               = idle;
    #1;
    is_cfg = (f == 7'h00);
    er     = is_cfg ? (exp_q.size() == 0 && idle) : (exp_q.size() < int'(DEPTH));
    chk("io_cmd_ready", 192'(io_cmd_ready), 192'(er));
    chk("busy", 192'(busy), 192'((exp_q.size() != 0) || !idle));
    if (v && er) begin
      if (is_cfg) begin
        pend_cfg  = 1'b1;
        pend_idx  = a[31:0];
        pend_data = b[W-1:0];
      end else begin
        pend_push = 1'b1;
        pend_cmd  = '{funct: f, rd: rd, rs1: a, rs2: b};
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    commit();
    reset        = 1'b0;
    io_cmd_valid = 1'b0;
    model_reset();
    #1;
    chk("reset_acc_valid", 192'(acc_cmd_valid), 192'(0));
    chk("reset_cfg_regs", 192'(cfg_regs), 192'(0));
    chk("reset_cmd_count", 192'(cmd_count), 192'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares the presented output against the model, pops on handshake.
  initial begin
    forever begin
      @(negedge clock);
      chk("acc_cmd_valid", 192'(acc_cmd_valid), 192'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("acc_cmd_head", 192'({acc_cmd_funct, acc_cmd_rd, acc_cmd_rs1, acc_cmd_rs2}),
            192'(exp_q[0]));
      chk("cmd_count", 192'(cmd_count), 192'(m_count));
      chk("cfg_regs", 192'(cfg_regs), 192'(model_flat()));
      chk("cfg_err", 192'(cfg_err), 192'(m_err));
      if (reset && exp_q.size() != 0 && acc_cmd_ready) begin
        void'(exp_q.pop_front());
        m_count++;
      end
    end
  end

  initial begin
    reset                  = 1'b0;
    io_cmd_valid           = 1'b0;
    io_cmd_bits_inst_funct = 7'h01;
    io_cmd_bits_inst_rd    = '0;
    io_cmd_bits_rs1        = '0;
    io_cmd_bits_rs2        = '0;
    acc_cmd_ready          = 1'b0;
    acc_idle               = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Idle after reset: compute ready, nothing valid, not busy.
    repeat (2) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Config write in range, then out of range.
    step(1'b1, 7'h00, 5'd3, 64'd2, 64'hDEADBEEF, 1'b0, 1'b1);
    step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 7'h00, 5'd0, 64'd5, 64'h1234, 1'b0, 1'b1);
    repeat (2) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Fill the FIFO, fifth push refused, then drain in order.
    for (int i = 1; i <= 5; i++)
      step(1'b1, 7'(i), 5'(i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    repeat (6) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1);

    // One-cycle latency, then head held while not ready.
    step(1'b1, 7'h09, 5'd7, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b1);
    repeat (3) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1);

    // Config write held off by a queued entry and by a busy core.
    step(1'b1, 7'h08, 5'd1, 64'd10, 64'd20, 1'b0, 1'b1);
    step(1'b1, 7'h00, 5'd0, 64'd1, 64'h55, 1'b0, 1'b1);
    step(1'b1, 7'h00, 5'd0, 64'd1, 64'h55, 1'b1, 1'b0);
    step(1'b1, 7'h00, 5'd0, 64'd1, 64'h55, 1'b0, 1'b0);
    step(1'b1, 7'h00, 5'd0, 64'd1, 64'h55, 1'b0, 1'b1);
    step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Reset with queued work and a non-zero config register.
    step(1'b1, 7'h00, 5'd0, 64'd0, 64'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'h10 + 7'(i), 5'(i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    do_reset();
    repeat (3) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic        v;
      logic [6:0]  f;
      logic [63:0] a;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        f = 7'h00;
        a = {$urandom, 32'($urandom_range(0, 4))};
      end else begin
        f = 7'($urandom_range(1, 127));
        a = {$urandom, $urandom};
      end
      step(v, f, 5'($urandom), a, {$urandom, $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    repeat (8) step(1'b0, 7'h01, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1);

    @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
